cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter WORD_NUM, default 32, meaning 64-bit words per cache line; power of two.
REQ-002 SHALL have parameter WORD_WID, default 64, meaning bits per word and per memory beat.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 miss_valid_i  input  1  data cache reports a miss.
REQ-007 miss_addr_i  input  32  byte address of the missing access.
REQ-008 miss_ready_o  output  1  controller idle; miss accepted when both valid and ready are high.
REQ-009 mem_req_o  output  1  burst read request to backing memory.
REQ-010 mem_addr_o  output  32  burst start address.
REQ-011 mem_ack_i  input  1  memory accepted the request.
REQ-012 mem_rvalid_i  input  1  read beat valid.
REQ-013 mem_rdata_i  input  WORD_WID  read beat data.
REQ-014 fill_we_o  output  1  write strobe into the cache data store.
REQ-015 fill_word_o  output  $clog2(WORD_NUM)  word index within the line being written.
REQ-016 fill_data_o  output  WORD_WID  word written.
REQ-017 fill_line_o  output  24  line address, latched miss_addr_i[31:8].
REQ-018 tag_we_o  output  1  one-cycle strobe to set the tag and valid bit for fill_line_o.
REQ-019 crit_valid_o  output  1  the beat now on fill_data_o is the requested word.
REQ-020 done_o  output  1  one-cycle refill-complete pulse.
REQ-021 busy_o  output  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, REQ, FILL and COMMIT.
REQ-023 IDLE SHALL drive miss_ready_o=1, latch miss_addr_i on accept, and move to REQ next cycle.
REQ-024 REQ SHALL hold mem_req_o=1 with mem_addr_o stable until mem_ack_i=1, then move to FILL with the beat counter set to 0.
REQ-025 FILL SHALL, on each cycle with mem_rvalid_i=1, combinationally drive fill_we_o=1 and fill_data_o=mem_rdata_i, and drive fill_word_o=(start_word+count) mod WORD_NUM.
REQ-026 The counter SHALL increment only on accepted beats, and FILL SHALL move to COMMIT after the WORD_NUM-th beat.
REQ-027 COMMIT SHALL assert tag_we_o and done_o for exactly one cycle, then return to IDLE.
REQ-028 crit_valid_o SHALL equal fill_we_o AND (fill_word_o == latched addr[7:3]).
REQ-029 mem_rvalid_i outside FILL (including the mem_ack_i cycle) SHALL be ignored.
REQ-030 miss_valid_i outside IDLE SHALL be ignored and not queued.
REQ-031 A gap cycle (mem_rvalid_i=0) in FILL SHALL hold all state, with fill_we_o=0.
REQ-032 Refill latency SHALL be 1 (REQ) + ack wait + beat cycles + 1 (COMMIT) cycles.

Reset
REQ-033 rst_i=1 at a clock edge SHALL force IDLE and clear the counter and the latched address, from any state.
REQ-034 While rst_i=1 and in the cycle after, miss_ready_o SHALL be 1 and all other outputs 0.
REQ-035 Reset mid-FILL SHALL abort the refill with no tag_we_o; partial data remains, and the tag stays invalid.

Configuration
REQ-036 Macro CACHE_REFILL_CRIT_WORD_FIRST_EN SHALL select critical-word-first refill.
REQ-037 With CACHE_REFILL_CRIT_WORD_FIRST_EN defined: start_word=addr[7:3], mem_addr_o={addr[31:3],3'b0}, and fill_word_o wraps from WORD_NUM-1 to 0.
REQ-038 Without CACHE_REFILL_CRIT_WORD_FIRST_EN: start_word=0 and mem_addr_o={addr[31:8],8'h00}.

Verification
REQ-039 Macro off, miss 0x0000_1238, ack after 2 cycles, 32 back-to-back beats -> mem_addr_o=0x0000_1200; words 0..31 in order; crit_valid_o on the 8th beat (word 7); fill_line_o=0x000012; tag_we_o/done_o one cycle after the last beat.
REQ-040 Macro on, same miss -> mem_addr_o=0x0000_1238; word order 7..31,0..6; crit_valid_o on the first beat.
REQ-041 Beats with mem_rvalid_i toggling 1,0,1,0 -> exactly 32 fill_we_o pulses; counter holds on gaps; COMMIT only after the 32nd beat.
REQ-042 rst_i pulsed after beat 10 -> no tag_we_o or done_o; next cycle miss_ready_o=1; a new miss 0x0000_4000 refills normally.
REQ-043 miss_valid_i held during FILL plus mem_rvalid_i asserted in REQ before ack -> both ignored; a single refill of exactly 32 beats.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: accepts a miss, issues one burst read and writes the beats into the data store.
// Define CACHE_REFILL_CRIT_WORD_FIRST_EN to fetch the missing word first and wrap around the line.
module cache_refill_ctrl #(
    parameter int WORD_NUM = 32,
    parameter int WORD_WID = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        miss_valid_i,
    input  logic [31:0]                 miss_addr_i,
    output logic                        miss_ready_o,
    output logic                        mem_req_o,
    output logic [31:0]                 mem_addr_o,
    input  logic                        mem_ack_i,
    input  logic                        mem_rvalid_i,
    input  logic [WORD_WID-1:0]         mem_rdata_i,
    output logic                        fill_we_o,
    output logic [$clog2(WORD_NUM)-1:0] fill_word_o,
    output logic [WORD_WID-1:0]         fill_data_o,
    output logic [23:0]                 fill_line_o,
    output logic                        tag_we_o,
    output logic                        crit_valid_o,
    output logic                        done_o,
    output logic                        busy_o
);

    localparam int IDX_W = $clog2(WORD_NUM);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORD_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [31:3]       addr_q, addr_d;
    logic [IDX_W-1:0]  start_word;
    logic [IDX_W-1:0]  crit_word;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       req_addr;

    assign crit_word = addr_q[3 +: IDX_W];
    assign word_idx  = start_word + count_q;

`ifdef CACHE_REFILL_CRIT_WORD_FIRST_EN
    assign start_word = crit_word;
    assign req_addr   = {addr_q[31:3], 3'b000};
`else
    assign start_word = '0;
    assign req_addr   = {addr_q[31:8], 8'h00};
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

    // NOTE: each combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (miss_valid_i) begin
                    addr_d  = miss_addr_i[31:3];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    count_d = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rvalid_i) begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_BEAT) state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // While reset is held the outputs already show the idle values, whatever state the flops hold.
    always_comb begin
        miss_ready_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        fill_we_o    = 1'b0;
        fill_word_o  = '0;
        fill_data_o  = '0;
        fill_line_o  = addr_q[31:8];
        tag_we_o     = 1'b0;
        crit_valid_o = 1'b0;
        done_o       = 1'b0;
        busy_o       = 1'b1;
        if (rst_i) begin
            miss_ready_o = 1'b1;
            fill_line_o  = '0;
            busy_o       = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    miss_ready_o = 1'b1;
                    busy_o       = 1'b0;
                end
                S_REQ: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = req_addr;
                end
                S_FILL: begin
                    fill_word_o = word_idx;
                    if (mem_rvalid_i) begin
                        fill_we_o    = 1'b1;
                        fill_data_o  = mem_rdata_i;
                        crit_valid_o = (word_idx == crit_word);
                    end
                end
                S_COMMIT: begin
                    tag_we_o = 1'b1;
                    done_o   = 1'b1;
                end
                default: busy_o = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: expected fill beats are queued as beats are driven and
// popped by a negedge monitor; define CACHE_REFILL_CRIT_WORD_FIRST_EN here too for the wrapped order.
module tb_cache_refill_ctrl;

    localparam int WN = 32;
    localparam int WW = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          miss_valid_i;
    logic [31:0]   miss_addr_i;
    logic          miss_ready_o;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_ack_i;
    logic          mem_rvalid_i;
    logic [WW-1:0] mem_rdata_i;
    logic          fill_we_o;
    logic [4:0]    fill_word_o;
    logic [WW-1:0] fill_data_o;
    logic [23:0]   fill_line_o;
    logic          tag_we_o;
    logic          crit_valid_o;
    logic          done_o;
    logic          busy_o;

    typedef struct packed {
        logic [4:0]    word;
        logic [WW-1:0] data;
        logic          crit;
    } beat_t;

    beat_t sb[$];
    beat_t mon_b;
    int    total = 0;
    int    bad = 0;
    int    fill_cnt = 0;
    int    tag_cnt = 0;
    int    done_cnt = 0;

    localparam logic [131:0] IDLE_VEC = {1'b1, 131'b0};

    cache_refill_ctrl #(.WORD_NUM(WN), .WORD_WID(WW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .miss_valid_i (miss_valid_i),
        .miss_addr_i  (miss_addr_i),
        .miss_ready_o (miss_ready_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .fill_we_o    (fill_we_o),
        .fill_word_o  (fill_word_o),
        .fill_data_o  (fill_data_o),
        .fill_line_o  (fill_line_o),
        .tag_we_o     (tag_we_o),
        .crit_valid_o (crit_valid_o),
        .done_o       (done_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [131:0] obs_vec();
        return {miss_ready_o, mem_req_o, mem_addr_o, fill_we_o, fill_word_o, fill_data_o,
                fill_line_o, tag_we_o, crit_valid_o, done_o, busy_o};
    endfunction

    always @(negedge clk_i) begin
        total++;
        if (fill_we_o) begin
            fill_cnt++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_fill got word=%0d data=%h, required no write", fill_word_o, fill_data_o);
            end else begin
                mon_b = sb.pop_front();
                if ({fill_word_o, fill_data_o, crit_valid_o} !== mon_b) begin
                    bad++;
                    $display("FAIL fill_beat got word=%0d data=%h crit=%b required word=%0d data=%h crit=%b",
                             fill_word_o, fill_data_o, crit_valid_o, mon_b.word, mon_b.data, mon_b.crit);
                end
            end
        end else if (crit_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL crit_without_we got crit=%b required 0", crit_valid_o);
        end
        if (tag_we_o === 1'b1) tag_cnt++;
        if (done_o === 1'b1) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        miss_valid_i = 1'b0;
        miss_addr_i = '0;
        mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        repeat (3) cyc();
        @(negedge clk_i);
        total++;
        if (obs_vec() !== IDLE_VEC) begin
            bad++;
            $display("FAIL reset_hold got %h required %h", obs_vec(), IDLE_VEC);
        end
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (obs_vec() !== IDLE_VEC) begin
            bad++;
            $display("FAIL reset_after got %h required %h", obs_vec(), IDLE_VEC);
        end
        cyc();
    endtask

    // Runs one miss; gaps inserts an idle cycle before every beat, noise holds miss_valid_i and
    // pulses mem_rvalid_i while waiting for ack, abort_at>0 pulses reset after that many beats.
    task automatic run_refill(input logic [31:0] addr, input int ack_wait, input bit gaps,
                              input bit noise, input int abort_at);
        logic [4:0]  sw;
        logic [4:0]  cw;
        logic [31:0] exp_maddr;
        beat_t       b;
        int          n;
        bit          aborted;
        cw = addr[7:3];
`ifdef CACHE_REFILL_CRIT_WORD_FIRST_EN
        sw = addr[7:3];
        exp_maddr = {addr[31:3], 3'b000};
`else
        sw = '0;
        exp_maddr = {addr[31:8], 8'h00};
`endif
        fill_cnt = 0;
        tag_cnt = 0;
        done_cnt = 0;
        aborted = 1'b0;

        n = 0;
        while (miss_ready_o !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        total++;
        if (miss_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout got ready=%b required 1", miss_ready_o);
        end

        miss_valid_i = 1'b1;
        miss_addr_i = addr;
        cyc();
        if (noise) miss_addr_i = addr ^ 32'h0001_0F00;
        else miss_valid_i = 1'b0;

        for (int i = 0; i <= ack_wait; i++) begin
            mem_ack_i = (i == ack_wait);
            mem_rvalid_i = noise;
            mem_rdata_i = {32'hDEAD_BEEF, 32'(i)};
            @(negedge clk_i);
            total++;
            if ({mem_req_o, mem_addr_o, busy_o, miss_ready_o} !== {1'b1, exp_maddr, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL req_phase got req=%b addr=%h busy=%b ready=%b required req=1 addr=%h busy=1 ready=0",
                         mem_req_o, mem_addr_o, busy_o, miss_ready_o, exp_maddr);
            end
            cyc();
        end
        mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b0;

        for (int k = 0; k < WN; k++) begin
            if (!aborted && abort_at > 0 && k == abort_at) aborted = 1'b1;
            if (!aborted) begin
                if (gaps) begin
                    mem_rvalid_i = 1'b0;
                    cyc();
                end
                mem_rvalid_i = 1'b1;
                mem_rdata_i = {$urandom(), $urandom()};
                b.word = sw + 5'(k);
                b.data = mem_rdata_i;
                b.crit = (b.word == cw);
                sb.push_back(b);
                cyc();
            end
        end
        mem_rvalid_i = 1'b0;
        miss_valid_i = 1'b0;

        if (aborted) begin
            rst_i = 1'b1;
            @(negedge clk_i);
            total++;
            if (obs_vec() !== IDLE_VEC) begin
                bad++;
                $display("FAIL abort_hold got %h required %h", obs_vec(), IDLE_VEC);
            end
            cyc();
            rst_i = 1'b0;
            @(negedge clk_i);
            total++;
            if (obs_vec() !== IDLE_VEC) begin
                bad++;
                $display("FAIL abort_after got %h required %h", obs_vec(), IDLE_VEC);
            end
            cyc();
            total++;
            if ({fill_cnt, tag_cnt, done_cnt, sb.size()} !== {abort_at, 32'd0, 32'd0, 32'd0}) begin
                bad++;
                $display("FAIL abort_counts got fills=%0d tags=%0d dones=%0d left=%0d required fills=%0d tags=0 dones=0 left=0",
                         fill_cnt, tag_cnt, done_cnt, sb.size(), abort_at);
            end
            sb.delete();
        end else begin
            @(negedge clk_i);
            total++;
            if ({tag_we_o, done_o, busy_o, miss_ready_o, fill_line_o} !== {4'b1110, addr[31:8]}) begin
                bad++;
                $display("FAIL commit got tag=%b done=%b busy=%b ready=%b line=%h required tag=1 done=1 busy=1 ready=0 line=%h",
                         tag_we_o, done_o, busy_o, miss_ready_o, fill_line_o, addr[31:8]);
            end
            cyc();
            @(negedge clk_i);
            total++;
            if ({tag_we_o, done_o, busy_o, miss_ready_o} !== 4'b0001) begin
                bad++;
                $display("FAIL back_idle got tag=%b done=%b busy=%b ready=%b required tag=0 done=0 busy=0 ready=1",
                         tag_we_o, done_o, busy_o, miss_ready_o);
            end
            total++;
            if ({fill_cnt, tag_cnt, done_cnt, sb.size()} !== {32'd32, 32'd1, 32'd1, 32'd0}) begin
                bad++;
                $display("FAIL refill_counts got fills=%0d tags=%0d dones=%0d left=%0d required fills=32 tags=1 dones=1 left=0",
                         fill_cnt, tag_cnt, done_cnt, sb.size());
            end
            sb.delete();
            cyc();
        end
    endtask

    task automatic test_line_order();
        run_refill(32'h0000_1238, 2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_gaps();
        run_refill(32'h0000_1238, 0, 1'b1, 1'b0, 0);
        run_refill(32'h00AB_CDF8, 1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_reset_mid_fill();
        run_refill(32'h0000_1238, 1, 1'b0, 1'b0, 10);
        run_refill(32'h0000_4000, 1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_ignored_inputs();
        run_refill(32'h0000_1238, 3, 1'b0, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        run_refill(32'h8000_00F0, 0, 1'b0, 1'b0, 0);
        run_refill(32'hFFFF_FF08, 0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_line_order();
        test_gaps();
        test_reset_mid_fill();
        test_ignored_inputs();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
